// File: rtl/offset_stage_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module  : offset_stage_arbiter_if
// Brief   : Requester, OffsetStage and downstream bundle for the arbiter.
// Revision: 1.0
// ============================================================================
interface offset_stage_arbiter_if #(
  parameter int BW   = 8,
  parameter int DIM  = 2,
  parameter int NREQ = 4,
  parameter int IDBW = $clog2(NREQ)
);
  logic [NREQ-1:0]                    req_rdy;
  logic [NREQ-1:0]                    req_ack;
  logic [NREQ-1:0][DIM-1:0][BW-1:0]   i_ofs_beg;
  logic [NREQ-1:0][DIM-1:0][BW-1:0]   i_ofs_end;
  logic [NREQ-1:0][DIM-1:0][BW-1:0]   i_ofs_gend;
  logic [NREQ-1:0][DIM-1:0][BW-1:0]   i_stride;
  logic                               os_rdy;
  logic                               os_ack;
  logic [DIM-1:0][BW-1:0]             os_ofs_beg;
  logic [DIM-1:0][BW-1:0]             os_ofs_end;
  logic [DIM-1:0][BW-1:0]             os_ofs_gend;
  logic [DIM-1:0][BW-1:0]             os_stride;
  logic                               os_dst_rdy;
  logic                               os_dst_ack;
  logic [DIM-1:0][BW-1:0]             i_ofs;
  logic [DIM-1:0][BW-1:0]             i_lofs;
  logic                               i_islast;
  logic                               out_rdy;
  logic                               out_ack;
  logic [DIM-1:0][BW-1:0]             o_ofs;
  logic [DIM-1:0][BW-1:0]             o_lofs;
  logic                               o_islast;
  logic [IDBW-1:0]                    o_id;
  logic                               o_busy;

  modport master (
    input  req_rdy, i_ofs_beg, i_ofs_end, i_ofs_gend, i_stride,
    input  os_ack, os_dst_rdy, i_ofs, i_lofs, i_islast, out_ack,
    output req_ack, os_rdy, os_ofs_beg, os_ofs_end, os_ofs_gend, os_stride,
    output os_dst_ack, out_rdy, o_ofs, o_lofs, o_islast, o_id, o_busy
  );

  modport slave (
    output req_rdy, i_ofs_beg, i_ofs_end, i_ofs_gend, i_stride,
    output os_ack, os_dst_rdy, i_ofs, i_lofs, i_islast, out_ack,
    input  req_ack, os_rdy, os_ofs_beg, os_ofs_end, os_ofs_gend, os_stride,
    input  os_dst_ack, out_rdy, o_ofs, o_lofs, o_islast, o_id, o_busy
  );
endinterface
`default_nettype wire

// File: rtl/offset_stage_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : offset_stage_arbiter
// Brief   : Round-robin sharing of one OffsetStage among NREQ requesters.
// Revision: 1.0
// ============================================================================
module offset_stage_arbiter #(
  parameter int BW   = 8,
  parameter int DIM  = 2,
  parameter int NREQ = 4,
  parameter int IDBW = $clog2(NREQ)
) (
  input wire                      i_clk,
  input wire                      i_rst,
  offset_stage_arbiter_if.master  bus
);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_BUSY = 1'b1
  } state_t;

  state_t                  r_state;
  logic [IDBW-1:0]         r_ptr;
  logic [IDBW-1:0]         r_id;
  logic                    r_src_done;
  logic                    r_last_done;
  logic [DIM-1:0][BW-1:0]  r_beg;
  logic [DIM-1:0][BW-1:0]  r_end;
  logic [DIM-1:0][BW-1:0]  r_gend;
  logic [DIM-1:0][BW-1:0]  r_stride;

  logic                    w_any;
  logic [IDBW-1:0]         w_win;
  logic [IDBW-1:0]         w_idx;
  logic                    w_busy;
  logic                    w_os_rdy;
  logic                    w_out_rdy;
  logic                    w_src_evt;
  logic                    w_last_evt;
  logic                    w_src_all;
  logic                    w_last_all;

  // Scan starts one past the last winner, so the last winner has lowest priority.
  always_comb begin
    w_any = 1'b0;
    w_win = '0;
    w_idx = '0;
    for (int k = 1; k <= NREQ; k++) begin
      w_idx = IDBW'((int'(r_ptr) + k) % NREQ);
      if (!w_any && bus.req_rdy[w_idx]) begin
        w_any = 1'b1;
        w_win = w_idx;
      end
    end
  end

  assign w_busy     = (r_state == S_BUSY);
  assign w_os_rdy   = w_busy && !r_src_done;
  assign w_out_rdy  = w_busy && bus.os_dst_rdy && !r_last_done;
  assign w_src_evt  = w_os_rdy && bus.os_ack;
  assign w_last_evt = w_out_rdy && bus.out_ack && bus.i_islast;
  assign w_src_all  = r_src_done || w_src_evt;
  assign w_last_all = r_last_done || w_last_evt;

  assign bus.req_ack     = (!w_busy && w_any) ? (NREQ'(1) << w_win) : '0;
  assign bus.os_rdy      = w_os_rdy;
  assign bus.os_ofs_beg  = r_beg;
  assign bus.os_ofs_end  = r_end;
  assign bus.os_ofs_gend = r_gend;
  assign bus.os_stride   = r_stride;
  assign bus.out_rdy     = w_out_rdy;
  assign bus.os_dst_ack  = w_out_rdy && bus.out_ack;
  assign bus.o_ofs       = w_busy ? bus.i_ofs  : '0;
  assign bus.o_lofs      = w_busy ? bus.i_lofs : '0;
  assign bus.o_islast    = w_busy && bus.i_islast;
  assign bus.o_id        = r_id;
  assign bus.o_busy      = w_busy;

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_state     <= S_IDLE;
      r_ptr       <= IDBW'(NREQ - 1);
      r_id        <= '0;
      r_src_done  <= 1'b0;
      r_last_done <= 1'b0;
      r_beg       <= '0;
      r_end       <= '0;
      r_gend      <= '0;
      r_stride    <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_state     <= S_BUSY;
            r_ptr       <= w_win;
            r_id        <= w_win;
            r_src_done  <= 1'b0;
            r_last_done <= 1'b0;
            r_beg       <= bus.i_ofs_beg[w_win];
            r_end       <= bus.i_ofs_end[w_win];
            r_gend      <= bus.i_ofs_gend[w_win];
            r_stride    <= bus.i_stride[w_win];
          end
        end
        S_BUSY: begin
          r_src_done  <= w_src_all;
          r_last_done <= w_last_all;
          // Both the src ack and the last beat may land in either order.
          if (w_src_all && w_last_all) begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire
